// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive frame engine.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    BRK_WAIT
  } rx_state_e;

  localparam int unsigned MIN_CHAR_LEN = 5;

  // Parity bit the transmitter should have sent for the first len bits of data.
  function automatic logic expected_parity(input logic [31:0] data,
                                           input int unsigned len,
                                           input logic eps,
                                           input logic sp);
    logic acc;
    acc = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < len) acc = acc ^ data[i];
    end
    return sp ? ~eps : (acc ^ ~eps);
  endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// Synchroniser, oversample tick counter and mid-bit sample strobe for the UART receiver.
// Optional UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote around the bit centre.
module uart_rx_bit_sampler #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic pclk,
  input  logic preset,
  input  logic baud_tick,
  input  logic serial_in,
  input  logic restart,
  input  logic first_bit,
  output logic line,
  output logic line_fall,
  output logic sample_strobe,
  output logic sample_bit
);
  import uart_rx_pkg::*;

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned HALF  = OVERSAMPLE / 2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLE - 1);

  // With voting, the strobe lands on the last of the three samples, one tick after the centre.
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [CNT_W-1:0] FIRST_PT = CNT_W'(HALF);
`else
  localparam logic [CNT_W-1:0] FIRST_PT = CNT_W'(HALF - 1);
`endif

  logic             sync1;
  logic             sync2;
  logic             line_prev;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] strobe_at;

  always_ff @(posedge pclk) begin
    if (preset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync1     <= serial_in;
      sync2     <= sync1;
      line_prev <= sync2;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset || restart) begin
      count <= '0;
    end else if (baud_tick) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign strobe_at     = first_bit ? FIRST_PT : LAST;
  assign sample_strobe = baud_tick && (count == strobe_at);
  assign line          = sync2;
  assign line_fall     = line_prev & ~sync2;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic vote_a;
  logic vote_b;

  always_ff @(posedge pclk) begin
    if (preset) begin
      vote_a <= 1'b0;
      vote_b <= 1'b0;
    end else if (baud_tick) begin
      if (count == strobe_at - CNT_W'(2)) vote_a <= sync2;
      if (count == strobe_at - CNT_W'(1)) vote_b <= sync2;
    end
  end

  assign sample_bit = (vote_a & vote_b) | (vote_a & sync2) | (vote_b & sync2);
`else
  assign sample_bit = sync2;
`endif

endmodule

// File: rtl/uart_rx_frame_engine.sv
// UART receive frame engine: start detect, 5..DATA_W data bits, parity, 1/2 stop bits,
// valid/ready holding register with error status. Optional UART_RX_MAJORITY_VOTE_EN.
module uart_rx_frame_engine #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned LEN_W      = $clog2(DATA_W + 1)
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              baud_tick,
  input  logic              rx_en,
  input  logic              uart_rxd,
  input  logic              loop,
  input  logic              loop_txd,
  input  logic [LEN_W-1:0]  char_len,
  input  logic              pen,
  input  logic              eps,
  input  logic              sp,
  input  logic              stb,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              parity_error,
  output logic              frame_error,
  output logic              break_detect,
  output logic              overrun_error,
  output logic              busy
);
  import uart_rx_pkg::*;

  rx_state_e         state;
  rx_state_e         state_next;
  logic              serial_in;
  logic              line;
  logic              line_fall;
  logic              sample_strobe;
  logic              sample_bit;
  logic              restart;
  logic              start_frame;
  logic              complete;
  logic              final_stop;
  logic              last_bit;
  logic [LEN_W-1:0]  len_clamped;
  logic [LEN_W-1:0]  cfg_len;
  logic              cfg_pen;
  logic              cfg_eps;
  logic              cfg_sp;
  logic              cfg_stb;
  logic [LEN_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shift_data;
  logic              par_sample;
  logic              stop_sample;

  assign serial_in = loop ? loop_txd : uart_rxd;

  uart_rx_bit_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .pclk         (pclk),
    .preset       (preset),
    .baud_tick    (baud_tick),
    .serial_in    (serial_in),
    .restart      (restart),
    .first_bit    (state == START),
    .line         (line),
    .line_fall    (line_fall),
    .sample_strobe(sample_strobe),
    .sample_bit   (sample_bit)
  );

  always_comb begin
    len_clamped = char_len;
    if (char_len < LEN_W'(MIN_CHAR_LEN)) len_clamped = LEN_W'(MIN_CHAR_LEN);
    else if (char_len > LEN_W'(DATA_W)) len_clamped = LEN_W'(DATA_W);
  end

  assign last_bit = (bit_idx == cfg_len - 1'b1);

  always_ff @(posedge pclk) begin
    if (preset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state != IDLE && !rx_en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:     if (rx_en && line_fall) state_next = START;
        START:    if (sample_strobe) state_next = sample_bit ? IDLE : DATA;
        DATA:     if (sample_strobe && last_bit) state_next = cfg_pen ? PARITY : STOP1;
        PARITY:   if (sample_strobe) state_next = STOP1;
        STOP1:    if (sample_strobe) state_next = cfg_stb ? STOP2 : (sample_bit ? IDLE : BRK_WAIT);
        STOP2:    if (sample_strobe) state_next = stop_sample ? IDLE : BRK_WAIT;
        BRK_WAIT: if (line) state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  // STOP2 is only timed, so the framing/break decision always uses the STOP1 sample.
  always_comb begin
    busy        = (state != IDLE);
    restart     = (state_next != state);
    start_frame = (state == IDLE) && (state_next == START);
    complete    = rx_en && sample_strobe &&
                  (((state == STOP1) && !cfg_stb) || (state == STOP2));
    final_stop  = (state == STOP2) ? stop_sample : sample_bit;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      cfg_len       <= '0;
      cfg_pen       <= 1'b0;
      cfg_eps       <= 1'b0;
      cfg_sp        <= 1'b0;
      cfg_stb       <= 1'b0;
      bit_idx       <= '0;
      shift_data    <= '0;
      par_sample    <= 1'b0;
      stop_sample   <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      frame_error   <= 1'b0;
      break_detect  <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      if (start_frame) begin
        cfg_len    <= len_clamped;
        cfg_pen    <= pen;
        cfg_eps    <= eps;
        cfg_sp     <= sp;
        cfg_stb    <= stb;
        bit_idx    <= '0;
        shift_data <= '0;
      end
      if (sample_strobe) begin
        case (state)
          DATA: begin
            for (int unsigned i = 0; i < DATA_W; i++) begin
              if (32'(bit_idx) == i) shift_data[i] <= sample_bit;
            end
            bit_idx <= bit_idx + 1'b1;
          end
          PARITY:  par_sample  <= sample_bit;
          STOP1:   stop_sample <= sample_bit;
          default: ;
        endcase
      end
      if (complete) begin
        rx_data       <= shift_data;
        rx_valid      <= 1'b1;
        parity_error  <= cfg_pen &&
                         (par_sample != expected_parity(32'(shift_data), 32'(cfg_len), cfg_eps, cfg_sp));
        frame_error   <= ~final_stop;
        break_detect  <= (shift_data == '0) && (!cfg_pen || !par_sample) && !final_stop;
        overrun_error <= rx_valid && !rx_ready;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_frame_engine.md
Name: uart_rx_frame_engine

Overview:
- Parametrised successor to the UART receive shift path.
- Does start-bit detection, oversampled mid-bit sampling, character lengths 5..DATA_W, optional parity (odd/even/stick), 1 or 2 stop bits.
- Reports parity, framing, break and overrun status through a valid/ready holding register.
- Sits between the baud generator / loopback mux and the RX FIFO in the UART IP.

Parameters:
- DATA_W, 8: maximum character length in bits; must be ≥ 5.
- OVERSAMPLE, 16: baud_tick pulses per bit period; must be even and ≥ 4.
- LEN_W, $clog2(DATA_W+1): width of char_len.

Ports:
- pclk  in  1  clock.
- preset  in  1  reset.
- baud_tick  in  1  one-cycle oversample strobe.
- rx_en  in  1  receiver enable.
- uart_rxd  in  1  asynchronous serial input.
- loop  in  1  loopback select.
- loop_txd  in  1  transmitter output used when loop=1.
- char_len  in  LEN_W  data bits per character (5..DATA_W).
- pen  in  1  parity enable.
- eps  in  1  even parity select.
- sp  in  1  stick parity.
- stb  in  1  0: one stop bit, 1: two stop bits.
- rx_data  out  DATA_W  received character, LSB-first, right-justified, upper bits zero.
- rx_valid  out  1  holding register full.
- rx_ready  in  1  consumer accepts.
- parity_error  out  1  status for the held character.
- frame_error  out  1  status for the held character.
- break_detect  out  1  status for the held character.
- overrun_error  out  1  status for the held character.
- busy  out  1  FSM not in IDLE.

Behaviour:
- One clock; reset is synchronous and active-high (pclk, preset). All outputs are 0 at reset, FSM is in IDLE, counters are 0.
- Input path:
  - serial_in = loop ? loop_txd : uart_rxd.
  - serial_in passes through a 2-flop synchroniser reset to 1.
  - All sampling uses the synchronised value.
- Tick counter: increments only on baud_tick and clears on every state change. "Sample point" is the tick where count = OVERSAMPLE/2-1, measured from the entry of START. Subsequent bits are sampled every OVERSAMPLE ticks.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT.
  - IDLE → START on a synchronised 1→0 transition while rx_en=1.
  - START, at the sample point:
    - line=1 → IDLE (false start, nothing reported).
    - line=0 → DATA.
  - DATA: shift char_len bits LSB first; bit index counter 0..char_len-1. Then → PARITY if pen, else → STOP1.
  - PARITY: sample one bit. Expected value:
    - sp=1: ~eps.
    - sp=0: XOR of data bits XOR ~eps.
  - STOP1: sample the bit.
    - If stb=1 → STOP2.
    - Otherwise complete the character.
  - STOP2: bit is timed only, never checked. Then complete the character.
  - After completion:
    - Stop bit was 0 → BRK_WAIT.
    - Otherwise → IDLE.
  - BRK_WAIT → IDLE once the synchronised line reads 1.
- Completion occurs the cycle after the final sampling tick:
  - rx_data, parity_error (mismatch and pen), frame_error (STOP1 sample = 0) and break_detect (all data, parity and stop samples = 0) load together.
  - rx_valid is set in the same cycle.
- Handshake:
  - rx_valid stays high until the cycle rx_valid & rx_ready, then clears next edge.
  - Completion while rx_valid=1 and not being accepted: the new character overwrites the holding register and overrun_error=1 is loaded with it.
  - Completion in the same cycle as acceptance: new character loaded, rx_valid stays 1, overrun_error=0.
- char_len outside 5..DATA_W is clamped to the nearest limit.
- Config inputs are sampled at START entry and held for the character. Changes mid-character have no effect until the next frame.
- rx_en deasserted mid-character: next cycle the FSM returns to IDLE and the partial character is discarded. The holding register is untouched.
- preset mid-character: immediate return to reset state, and the holding register is cleared.

Optional Feature:
- Macro UART_RX_MAJORITY_VOTE_EN.
- Defined: each bit value is the 2-of-3 majority of samples at ticks OVERSAMPLE/2-2, OVERSAMPLE/2-1 and OVERSAMPLE/2. START false-start rejection uses the majority value.
- Undefined: single sample at OVERSAMPLE/2-1. No vote registers are generated.

Decomposition:
- Package uart_rx_pkg holds:
  - state enum rx_state_e.
  - MIN_CHAR_LEN=5.
  - function expected_parity(data, len, eps, sp).
- Sub-module uart_rx_bit_sampler holds the synchroniser, tick counter and optional majority vote. Outputs are sample_strobe and sample_bit.
- The FSM, shift register and holding register stay in the top module.

Test Plan:
- Setup for all scenarios: OVERSAMPLE=16, baud_tick=1 every cycle.
- 8N1 0xA5 (char_len=8, pen=0, stb=0) → rx_data=0xA5, rx_valid=1, all errors 0. Accept the next cycle with rx_ready=1 → rx_valid=0.
- 7E1 0x41 (char_len=7, pen=1, eps=1), correct parity 0 → parity_error=0. The same frame with parity bit 1 → parity_error=1, rx_data=0x41.
- 5-bit 0x15 with stop bit 0 → frame_error=1, break_detect=0, busy holds in BRK_WAIT until line=1. An all-zero frame (0x00, stop 0) → break_detect=1, frame_error=1.
- 6-cycle low glitch on an idle line → no rx_valid, FSM returns to IDLE, busy pulses only during START.
- Two back-to-back 0x11, 0x22 with rx_ready=0 → rx_data=0x22, overrun_error=1. Repeat with rx_ready=1 on the completion cycle → overrun_error=0.
- preset and rx_en=0 asserted during DATA bit 3 → no rx_valid. A following 0x5A is received correctly. With loop=1, loop_txd driving 0x3C while uart_rxd is held at 1 → rx_data=0x3C.
